// File: rtl/tw_factor_gen.sv
`default_nettype none
// ============================================================================
// Module  : tw_factor_gen
// Brief   : Radix-2 DIF FFT twiddle generator, quarter-wave ROM with folding.
// Revision: 1.0  initial release
// ============================================================================
module tw_factor_gen #(
  parameter int SIZE           = 10,
  parameter int word_length_tw = 14,
  parameter int STAGE_W        = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [STAGE_W-1:0]               stage,
  input  logic                             en_rd,
  output logic signed [word_length_tw-1:0] cos_data,
  output logic signed [word_length_tw-1:0] sin_data,
  output logic                             tw_valid,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int c_n   = 1 << SIZE;
  localparam int c_q   = c_n / 4;
  localparam int c_one = 1 << (word_length_tw - 2);
  localparam int c_aw  = SIZE - 1;

  localparam logic [c_aw-1:0]    c_qa     = c_aw'(c_q);
  localparam logic [c_aw-1:0]    c_last   = {c_aw{1'b1}};
  localparam logic [STAGE_W:0]   c_size_w = (STAGE_W + 1)'(SIZE);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;

  // Elaboration-time cosine via Taylor series; angle never exceeds pi/2.
  function automatic logic [word_length_tw-1:0] q_calc(input int m);
    real x, term, sum;
    x    = 6.283185307179586 * $itor(m) / $itor(c_n);
    sum  = 1.0;
    term = 1.0;
    for (int i = 1; i < 24; i++) begin
      term = -term * x * x / $itor((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return word_length_tw'($rtoi(sum * $itor(c_one) + 0.5));
  endfunction

  logic [word_length_tw-1:0] w_rom [0:c_q];

  for (genvar m = 0; m <= c_q; m++) begin : g_rom
    localparam logic [word_length_tw-1:0] c_val = q_calc(m);
    assign w_rom[m] = c_val;
  end

  logic [1:0]                r_state;
  logic [c_aw-1:0]           r_b;
  logic [STAGE_W-1:0]        r_stage;
  logic                      r_v1;
  logic [word_length_tw-1:0] r_qa;
  logic [word_length_tw-1:0] r_qb;
  logic                      r_quad;
  logic [word_length_tw-1:0] r_cos;
  logic [word_length_tw-1:0] r_sin;
  logic                      r_valid;
  logic                      r_done;
  logic                      r_err;

  logic [c_aw-1:0] w_k;
  logic            w_hi;
  logic [c_aw-1:0] w_a1;
  logic [c_aw-1:0] w_a2;
  logic            w_stage_bad;

  // (b << s) truncated to SIZE-1 bits equals (b mod 2^(SIZE-1-s)) << s.
  always_comb begin
    w_k  = r_b << r_stage;
    w_hi = (w_k > c_qa);
    w_a1 = w_hi ? (c_aw'(0) - w_k) : w_k;
    w_a2 = w_hi ? (w_k - c_qa) : (c_qa - w_k);
  end

  assign w_stage_bad = ({1'b0, stage} >= c_size_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_b     <= '0;
      r_stage <= '0;
      r_v1    <= 1'b0;
      r_qa    <= '0;
      r_qb    <= '0;
      r_quad  <= 1'b0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            if (w_stage_bad) begin
              r_err <= 1'b1;
            end else begin
              r_stage <= stage;
              r_b     <= '0;
              r_state <= c_run;
            end
          end
        end
        c_run: begin
          if (en_rd) begin
            r_b <= r_b + 1'b1;
            if (r_b == c_last) r_state <= c_drain;
          end
        end
        c_drain: begin
          // The item in stage 1 is the last one; it reaches the output now.
          if (en_rd) begin
            r_done  <= 1'b1;
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase

      if (en_rd) begin
        r_v1 <= (r_state == c_run);
        if (r_state == c_run) begin
          r_qa   <= w_rom[w_a1];
          r_qb   <= w_rom[w_a2];
          r_quad <= w_hi;
        end
        r_valid <= r_v1;
        if (r_v1) begin
          r_cos <= r_quad ? -r_qa : r_qa;
          r_sin <= -r_qb;
        end
      end
    end
  end

  assign cos_data = r_cos;
  assign sin_data = r_sin;
  assign tw_valid = r_valid;
  assign busy     = (r_state == c_run) || (r_state == c_drain);
  assign done     = r_done;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tw_factor_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_tw_factor_gen
// Brief   : Directed self-checking bench for tw_factor_gen (SIZE=4 and 10).
// Revision: 1.0  initial release
// ============================================================================
module tb_tw_factor_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start4, en4, start10, en10;
  logic [3:0]         stage4, stage10;
  logic signed [13:0] cos4, sin4, cos10, sin10;
  logic               valid4, busy4, done4, err4;
  logic               valid10, busy10, done10, err10;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_cos [8] = '{4096, 3784, 2896, 1567, 0, -1567, -2896, -3784};
  int exp_sin [8] = '{0, -1567, -2896, -3784, -4096, -3784, -2896, -1567};

  tw_factor_gen #(.SIZE(4), .word_length_tw(14), .STAGE_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stage(stage4), .en_rd(en4),
    .cos_data(cos4), .sin_data(sin4), .tw_valid(valid4),
    .busy(busy4), .done(done4), .err(err4)
  );

  tw_factor_gen #(.SIZE(10), .word_length_tw(14), .STAGE_W(4)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .stage(stage10), .en_rd(en10),
    .cos_data(cos10), .sin_data(sin10), .tw_valid(valid10),
    .busy(busy10), .done(done10), .err(err10)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp);
    n_tests++;
    assert ((obs - exp <= 1) && (obs - exp >= -1)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (+-1)", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int round_afz(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Start a SIZE=4 sequence and collect outputs until done or stop_after.
  task automatic run4(input int stg, input bit rnd, input bit inj,
                      input int stop_after, output int got);
    start4 = 1'b1;
    stage4 = stg[3:0];
    tick();
    start4 = 1'b0;
    check("busy_after_start", busy4, 1);
    check("valid_low_at_start", valid4, 0);
    got = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bit e;
      int pc, ps, pv, k;
      e  = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      en4 = e;
      pc = cos4;
      ps = sin4;
      pv = valid4;
      if (inj && cyc == 3) begin
        start4 = 1'b1;
        stage4 = 4'd5;
      end
      tick();
      start4 = 1'b0;
      if (inj && cyc == 3) check("start_in_run_no_err", err4, 0);
      if (!e) begin
        check("stall_cos", cos4, pc);
        check("stall_sin", sin4, ps);
        check("stall_valid", valid4, pv);
      end else if (valid4) begin
        k = (got % (1 << (3 - stg))) << stg;
        check($sformatf("cos_s%0d_n%0d", stg, got), cos4, exp_cos[k]);
        check($sformatf("sin_s%0d_n%0d", stg, got), sin4, exp_sin[k]);
        if (!rnd && got == 0) check("first_latency", cyc, 2);
        got++;
        check($sformatf("done_s%0d_n%0d", stg, got), done4, (got == 8) ? 1 : 0);
        if (got == stop_after || done4) break;
      end
    end
  endtask

  initial begin
    int got;
    real ang;
    rst = 1'b1;
    start4 = 1'b0; en4 = 1'b0; stage4 = '0;
    start10 = 1'b0; en10 = 1'b0; stage10 = '0;
    tick();
    tick();
    check("rst_cos", cos4, 0);
    check("rst_sin", sin4, 0);
    check("rst_valid", valid4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_err", err4, 0);
    rst = 1'b0;
    en4 = 1'b1;
    tick();

    // Stage 0 full sequence, then back-to-back stages 2 and 3.
    run4(0, 1'b0, 1'b0, 8, got);
    check("count_s0", got, 8);
    run4(2, 1'b0, 1'b0, 8, got);
    check("count_s2", got, 8);
    run4(3, 1'b0, 1'b0, 8, got);
    check("count_s3", got, 8);
    en4 = 1'b1;
    tick();
    check("drained_valid", valid4, 0);
    check("drained_done", done4, 0);
    check("drained_busy", busy4, 0);

    // Random stalls plus a start pulse during RUN.
    run4(0, 1'b1, 1'b1, 8, got);
    check("count_s0_stall", got, 8);
    en4 = 1'b1;
    tick();

    // Illegal stage.
    start4 = 1'b1;
    stage4 = 4'd5;
    tick();
    start4 = 1'b0;
    check("err_pulse", err4, 1);
    check("err_busy", busy4, 0);
    check("err_valid", valid4, 0);
    tick();
    check("err_clear", err4, 0);
    check("err_busy2", busy4, 0);
    check("err_valid2", valid4, 0);

    // Asynchronous reset mid-RUN.
    run4(0, 1'b0, 1'b0, 3, got);
    check("count_before_rst", got, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_cos", cos4, 0);
    check("arst_sin", sin4, 0);
    check("arst_valid", valid4, 0);
    check("arst_busy", busy4, 0);
    check("arst_done", done4, 0);
    tick();
    check("arst_done2", done4, 0);
    rst = 1'b0;
    en4 = 1'b1;
    tick();
    run4(1, 1'b0, 1'b0, 8, got);
    check("count_s1", got, 8);

    // SIZE=10 stage 0 against the ideal twiddles.
    en10 = 1'b1;
    start10 = 1'b1;
    stage10 = 4'd0;
    tick();
    start10 = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      if (valid10) begin
        ang = 6.283185307179586 * $itor(got) / 1024.0;
        check_tol($sformatf("cos10_k%0d", got), cos10, round_afz(4096.0 * $cos(ang)));
        check_tol($sformatf("sin10_k%0d", got), sin10, -round_afz(4096.0 * $sin(ang)));
        if (got == 256) begin
          check("cos10_k256", cos10, 0);
          check("sin10_k256", sin10, -4096);
        end
        got++;
        if (done10) break;
      end
    end
    check("count10", got, 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
